// File: rtl/bcd_timer_pkg.sv
// rtl/bcd_timer_pkg.sv - shared types, BCD constants and digit clamp for the countdown timer
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// rtl/bcd_digit_down.sv - one BCD digit of the ripple-borrow down counter
module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic       clock,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       borrow_in,
    input  logic       enable,
    output logic [3:0] digit,
    output logic       borrow_out,
    output logic       is_zero
);

    logic [3:0] digit_q, digit_d;

    assign digit      = digit_q;
    assign is_zero    = (digit_q == BCD_ZERO);
    assign borrow_out = is_zero && borrow_in;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_digit;
        end else if (enable && borrow_in) begin
            digit_d = is_zero ? BCD_MAX : (digit_q - 4'd1);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - N-digit BCD countdown timer with prescaler, pause and auto-reload
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE_W = 26
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    clear,
    input  logic                    auto_reload,
    input  logic [PRESCALE_W-1:0]   tick_div,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    running,
    output logic                    done,
    output logic                    expired
);

    localparam int W = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] LSB_MASK = NUM_DIGITS'(1);

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [W-1:0]          reload_q, reload_d;
    logic                  running_q, done_q, expired_q, expired_d;

    logic [W-1:0]          load_clamped;
    logic [W-1:0]          dig_load_value;
    logic                  dig_load, dig_tick;
    logic [NUM_DIGITS-1:0] is_zero;
    logic [NUM_DIGITS:0]   borrow;
    logic                  all_zero, last_count;

    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign load_clamped[4*g +: 4] = clamp_bcd(load_value[4*g +: 4]);

        bcd_digit_down u_digit (
            .clock      (clock),
            .rst        (rst),
            .load       (dig_load),
            .load_digit (dig_load_value[4*g +: 4]),
            .borrow_in  (borrow[g]),
            .enable     (dig_tick),
            .digit      (digits[4*g +: 4]),
            .borrow_out (borrow[g+1]),
            .is_zero    (is_zero[g])
        );
    end

    assign all_zero   = &is_zero;
    // The count is exactly one when digit 0 holds 1 and every higher digit is zero.
    assign last_count = (digits[3:0] == 4'd1) && (&(is_zero | LSB_MASK));

    assign running = running_q;
    assign done    = done_q;
    assign expired = expired_q;

    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        reload_d       = reload_q;
        expired_d      = 1'b0;
        dig_load       = 1'b0;
        dig_load_value = load_clamped;
        dig_tick       = 1'b0;

        if (clear) begin
            state_d        = ST_IDLE;
            presc_d        = '0;
            dig_load       = 1'b1;
            dig_load_value = '0;
        end else if (load) begin
            state_d  = ST_IDLE;
            presc_d  = '0;
            reload_d = load_clamped;
            dig_load = 1'b1;
        end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSED)) begin
            if (all_zero) begin
                state_d   = ST_DONE;
                expired_d = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RUN) begin
            if (pause) begin
                state_d = ST_PAUSED;
            end
            // Expired while still running means auto-reload chose to continue.
            if (expired_q) begin
                dig_load       = 1'b1;
                dig_load_value = reload_q;
                presc_d        = '0;
            end else if (!pause) begin
                if (presc_q >= tick_div) begin
                    presc_d  = '0;
                    dig_tick = !borrow[NUM_DIGITS];
                    if (last_count) begin
                        expired_d = 1'b1;
                        if (!auto_reload || reload_q == '0) begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    presc_d = presc_q + PRESCALE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            reload_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            reload_q  <= reload_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
            expired_q <= expired_d;
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - scoreboard bench for the BCD countdown timer
module tb_bcd_countdown_timer;

    logic        clock;
    logic        rst;
    logic        load;
    logic [15:0] load_value;
    logic        start;
    logic        pause;
    logic        clear;
    logic        auto_reload;
    logic [25:0] tick_div;
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        expired;

    bcd_countdown_timer #(.NUM_DIGITS(4), .PRESCALE_W(26)) dut (
        .clock       (clock),
        .rst         (rst),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .pause       (pause),
        .clear       (clear),
        .auto_reload (auto_reload),
        .tick_div    (tick_div),
        .digits      (digits),
        .running     (running),
        .done        (done),
        .expired     (expired)
    );

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic        r;
        logic        dn;
        logic        e;
        string       name;
    } exp_t;

    exp_t  q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    string tname = "init";
    event  chk_ev;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int m;
        m = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic nxt();
        @(posedge clock);
        #1;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
    endtask

    task automatic ex(input logic [15:0] d, input logic r, input logic dn, input logic e);
        q.push_back('{cyc + 1, d, r, dn, e, tname});
        nxt();
    endtask

    task automatic check_now(input logic [15:0] d, input logic r, input logic dn, input logic e);
        q.push_back('{cyc, d, r, dn, e, tname});
        -> chk_ev;
        #1;
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clock or chk_ev);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                x = q.pop_front();
                checks++;
                if ({digits, running, done, expired} !== {x.d, x.r, x.dn, x.e}) begin
                    errors++;
                    $display("FAIL %s: got digits=%h running=%b done=%b expired=%b, want digits=%h running=%b done=%b expired=%b",
                             x.name, digits, running, done, expired, x.d, x.r, x.dn, x.e);
                end
            end
        end
    end

    initial begin
        load = 0; start = 0; pause = 0; clear = 0;
        auto_reload = 0; load_value = '0; tick_div = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        tname = "reset";
        check_now(16'h0000, 0, 0, 0);
        @(posedge clock);
        #1;
        rst = 1'b1;

        tname = "count12";
        load = 1; load_value = 16'h0012; tick_div = 0;
        ex(16'h0012, 0, 0, 0);
        start = 1;
        ex(16'h0012, 1, 0, 0);
        for (int v = 11; v >= 1; v--) ex(to_bcd(v), 1, 0, 0);
        ex(16'h0000, 0, 1, 1);
        ex(16'h0000, 0, 1, 0);
        tname = "start_in_done";
        start = 1;
        ex(16'h0000, 0, 1, 0);

        tname = "ripple";
        load = 1; load_value = 16'h1000; tick_div = 2;
        ex(16'h1000, 0, 0, 0);
        start = 1;
        ex(16'h1000, 1, 0, 0);
        ex(16'h1000, 1, 0, 0);
        ex(16'h1000, 1, 0, 0);
        ex(16'h0999, 1, 0, 0);
        ex(16'h0999, 1, 0, 0);
        ex(16'h0999, 1, 0, 0);
        ex(16'h0998, 1, 0, 0);
        clear = 1;
        ex(16'h0000, 0, 0, 0);

        tname = "pause";
        load = 1; load_value = 16'h0005; tick_div = 3;
        ex(16'h0005, 0, 0, 0);
        start = 1;
        ex(16'h0005, 1, 0, 0);
        repeat (3) ex(16'h0005, 1, 0, 0);
        ex(16'h0004, 1, 0, 0);
        repeat (3) ex(16'h0004, 1, 0, 0);
        ex(16'h0003, 1, 0, 0);
        ex(16'h0003, 1, 0, 0);
        pause = 1;
        ex(16'h0003, 0, 0, 0);
        repeat (10) ex(16'h0003, 0, 0, 0);
        tname = "resume";
        start = 1;
        ex(16'h0003, 1, 0, 0);
        ex(16'h0003, 1, 0, 0);
        ex(16'h0003, 1, 0, 0);
        ex(16'h0002, 1, 0, 0);
        clear = 1;
        ex(16'h0000, 0, 0, 0);

        tname = "auto_reload";
        auto_reload = 1;
        load = 1; load_value = 16'h0002; tick_div = 0;
        ex(16'h0002, 0, 0, 0);
        start = 1;
        ex(16'h0002, 1, 0, 0);
        ex(16'h0001, 1, 0, 0);
        ex(16'h0000, 1, 0, 1);
        ex(16'h0002, 1, 0, 0);
        ex(16'h0001, 1, 0, 0);
        ex(16'h0000, 1, 0, 1);
        auto_reload = 0;
        ex(16'h0002, 1, 0, 0);
        ex(16'h0001, 1, 0, 0);
        ex(16'h0000, 0, 1, 1);
        ex(16'h0000, 0, 1, 0);

        tname = "clamp";
        load = 1; load_value = 16'h00A3;
        ex(16'h0093, 0, 0, 0);
        load = 1; load_value = 16'hFA3C;
        ex(16'h9939, 0, 0, 0);
        clear = 1;
        ex(16'h0000, 0, 0, 0);

        tname = "start_zero";
        start = 1;
        ex(16'h0000, 0, 1, 1);
        ex(16'h0000, 0, 1, 0);

        tname = "clear_and_load";
        load = 1; load_value = 16'h0030; tick_div = 5;
        ex(16'h0030, 0, 0, 0);
        start = 1;
        ex(16'h0030, 1, 0, 0);
        ex(16'h0030, 1, 0, 0);
        clear = 1; load = 1; load_value = 16'h0077;
        ex(16'h0000, 0, 0, 0);
        ex(16'h0000, 0, 0, 0);
        start = 1;
        ex(16'h0000, 0, 1, 1);

        tname = "async_reset";
        load = 1; load_value = 16'h0050; tick_div = 0;
        ex(16'h0050, 0, 0, 0);
        start = 1;
        ex(16'h0050, 1, 0, 0);
        ex(16'h0049, 1, 0, 0);
        ex(16'h0048, 1, 0, 0);
        ex(16'h0047, 1, 0, 0);
        @(negedge clock);
        #1;
        rst = 1'b0;
        #1;
        check_now(16'h0000, 0, 0, 0);
        @(posedge clock);
        #1;
        rst = 1'b1;
        tname = "start_after_reset";
        start = 1;
        ex(16'h0000, 0, 1, 1);
        ex(16'h0000, 0, 1, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clock);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
